// File: rtl/secuenciador_rtc.sv
`timescale 1ns/1ps
// Purpose: sequences one RTC bus transaction (address phase, wait, data phase)
//          and drives the strobes, the AD bus and the external phase counter.
// Latency: 2*T_PULSO + T_ESPERA + 6 cycles from the inicio edge to the listo cycle.
// Backpressure: none. While ocupado is high, inicio is ignored and not queued.
// Ports: clk/reset (sync, active-high); request inputs inicio/lectura/direccion/
//        dato_escritura; bus_in read-back; cuenta/EN_cuenta/tiempo to contador_rtc;
//        CS_n/RD_n/WR_n/AD strobes; bus_out/bus_oe bus drive; dato_lectura,
//        ocupado, listo status.
module secuenciador_rtc #(
  parameter logic [5:0] T_PULSO  = 6'd10,
  parameter logic [5:0] T_ESPERA = 6'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       lectura,
  input  logic [7:0] direccion,
  input  logic [7:0] dato_escritura,
  input  logic [7:0] bus_in,
  input  logic [5:0] cuenta,
  output logic       EN_cuenta,
  output logic [5:0] tiempo,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] dato_lectura,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIR    = 3'd1,
    G1     = 3'd2,
    ESPERA = 3'd3,
    G2     = 3'd4,
    DATO   = 3'd5,
    FIN    = 3'd6
  } estado_t;

  estado_t    estado, estado_sig;
  logic       lectura_q, lectura_sig;
  logic [7:0] dir_q, dir_sig;
  logic [7:0] dato_q, dato_sig;

  logic       en_sig, cs_n_sig, rd_n_sig, wr_n_sig, ad_sig, oe_sig;
  logic [5:0] tiempo_sig;
  logic [7:0] bus_out_sig;

  // tiempo is a registered copy of the current phase's terminal value, so this
  // compare tracks the phase the counter is actually running.
  logic fin_fase;
  assign fin_fase = (cuenta == tiempo);

  // Next state, next captured request, and the outputs decoded from them.
  // Outputs are then registered, so they change on the same edge as the state
  // and never see inicio combinationally.
  always_comb begin
    estado_sig  = estado;
    lectura_sig = lectura_q;
    dir_sig     = dir_q;
    dato_sig    = dato_q;

    case (estado)
      IDLE: begin
        if (inicio) begin
          estado_sig  = DIR;
          lectura_sig = lectura;
          dir_sig     = direccion;
          dato_sig    = dato_escritura;
        end
      end
      DIR:     if (fin_fase) estado_sig = G1;
      G1:      estado_sig = ESPERA;
      ESPERA:  if (fin_fase) estado_sig = G2;
      G2:      estado_sig = DATO;
      DATO:    if (fin_fase) estado_sig = FIN;
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase

    en_sig      = 1'b0;
    tiempo_sig  = 6'd0;
    cs_n_sig    = 1'b1;
    rd_n_sig    = 1'b1;
    wr_n_sig    = 1'b1;
    ad_sig      = 1'b1;
    oe_sig      = 1'b0;
    bus_out_sig = 8'h00;

    case (estado_sig)
      DIR: begin
        en_sig      = 1'b1;
        tiempo_sig  = T_PULSO;
        cs_n_sig    = 1'b0;
        wr_n_sig    = 1'b0;
        ad_sig      = 1'b0;
        oe_sig      = 1'b1;
        bus_out_sig = dir_sig;
      end
      G1: ad_sig = 1'b0;
      ESPERA: begin
        en_sig     = 1'b1;
        tiempo_sig = T_ESPERA;
        ad_sig     = 1'b0;
      end
      DATO: begin
        en_sig     = 1'b1;
        tiempo_sig = T_PULSO;
        cs_n_sig   = 1'b0;
        if (lectura_sig) begin
          rd_n_sig = 1'b0;
        end else begin
          wr_n_sig    = 1'b0;
          oe_sig      = 1'b1;
          bus_out_sig = dato_sig;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= IDLE;
      lectura_q    <= 1'b0;
      dir_q        <= 8'h00;
      dato_q       <= 8'h00;
      EN_cuenta    <= 1'b0;
      tiempo       <= 6'd0;
      CS_n         <= 1'b1;
      RD_n         <= 1'b1;
      WR_n         <= 1'b1;
      AD           <= 1'b1;
      bus_oe       <= 1'b0;
      bus_out      <= 8'h00;
      dato_lectura <= 8'h00;
      ocupado      <= 1'b0;
      listo        <= 1'b0;
    end else begin
      estado    <= estado_sig;
      lectura_q <= lectura_sig;
      dir_q     <= dir_sig;
      dato_q    <= dato_sig;
      EN_cuenta <= en_sig;
      tiempo    <= tiempo_sig;
      CS_n      <= cs_n_sig;
      RD_n      <= rd_n_sig;
      WR_n      <= wr_n_sig;
      AD        <= ad_sig;
      bus_oe    <= oe_sig;
      bus_out   <= bus_out_sig;
      ocupado   <= (estado_sig != IDLE);
      listo     <= (estado_sig == FIN);
      // Sample the RTC on the last edge of the read strobe.
      if (estado == DATO && fin_fase && lectura_q)
        dato_lectura <= bus_in;
    end
  end

endmodule
